// File: rtl/trigger_latency_meter.sv
// Single-shot latency meter: counts clk cycles between a selected edge on
// start_in and a selected edge on stop_in, with timeout and saturation.
module trigger_latency_meter #(
  parameter int SYNC_STAGES = 3,
  parameter int CNT_BITS    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_in,
  input  logic                stop_in,
  input  logic [1:0]          start_edge,
  input  logic [1:0]          stop_edge,
  input  logic [CNT_BITS-1:0] timeout_cycles,
  input  logic                arm,
  input  logic                abort,
  output logic                busy,
  output logic                result_valid,
  output logic [CNT_BITS-1:0] measured_cycles,
  output logic                timed_out,
  output logic                overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COUNTING, S_DONE} state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d;
  logic [SYNC_STAGES-1:0] stop_sync_q, stop_sync_d;
  logic                   start_hist_q, start_hist_d;
  logic                   stop_hist_q, stop_hist_d;
  logic [1:0]             start_edge_q, start_edge_d;
  logic [1:0]             stop_edge_q, stop_edge_d;
  logic [CNT_BITS-1:0]    timeout_q, timeout_d;
  logic [CNT_BITS-1:0]    count_q, count_d;
  logic [CNT_BITS-1:0]    measured_q, measured_d;
  logic                   timed_out_q, timed_out_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   result_valid_q, result_valid_d;

  logic                   start_pulse, stop_pulse, count_sat;
  logic [CNT_BITS:0]      count_inc;

  // 00 rising, 01 falling, 10 both, 11 disabled
  function automatic logic edge_hit(input logic [1:0] sel, input logic cur, input logic prev);
    case (sel)
      2'b00:   edge_hit = cur & ~prev;
      2'b01:   edge_hit = ~cur & prev;
      2'b10:   edge_hit = cur ^ prev;
      default: edge_hit = 1'b0;
    endcase
  endfunction

  always_comb begin
    start_sync_d = {start_sync_q[SYNC_STAGES-2:0], start_in};
    stop_sync_d  = {stop_sync_q[SYNC_STAGES-2:0], stop_in};
    start_hist_d = start_sync_q[SYNC_STAGES-1];
    stop_hist_d  = stop_sync_q[SYNC_STAGES-1];

    // Both channels see the same chain depth, so synchronizer delay cancels.
    start_pulse = edge_hit(start_edge_q, start_sync_q[SYNC_STAGES-1], start_hist_q);
    stop_pulse  = edge_hit(stop_edge_q, stop_sync_q[SYNC_STAGES-1], stop_hist_q);
    count_inc   = {1'b0, count_q} + {{CNT_BITS{1'b0}}, 1'b1};
    count_sat   = (count_q == CNT_MAX);

    state_d      = state_q;
    start_edge_d = start_edge_q;
    stop_edge_d  = stop_edge_q;
    timeout_d    = timeout_q;
    count_d      = count_q;
    measured_d   = measured_q;
    timed_out_d  = timed_out_q;
    overflow_d   = overflow_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d      = S_ARMED;
            start_edge_d = start_edge;
            stop_edge_d  = stop_edge;
            timeout_d    = timeout_cycles;
            measured_d   = '0;
            timed_out_d  = 1'b0;
            overflow_d   = 1'b0;
          end
        end
        S_ARMED: begin
          if (start_pulse) begin
            count_d = '0;
            if (stop_pulse) begin
              state_d    = S_DONE;
              measured_d = '0;
            end else begin
              state_d = S_COUNTING;
            end
          end
        end
        S_COUNTING: begin
          // Stop takes priority over a coincident timeout.
          if (stop_pulse) begin
            state_d    = S_DONE;
            measured_d = count_sat ? CNT_MAX : count_inc[CNT_BITS-1:0];
            overflow_d = overflow_q | count_sat;
          end else if ((timeout_q != '0) && (count_inc == {1'b0, timeout_q})) begin
            state_d     = S_DONE;
            measured_d  = timeout_q;
            timed_out_d = 1'b1;
          end else if (count_sat) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_inc[CNT_BITS-1:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d         = (state_d == S_ARMED) || (state_d == S_COUNTING);
    result_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      start_sync_q   <= '0;
      stop_sync_q    <= '0;
      start_hist_q   <= 1'b0;
      stop_hist_q    <= 1'b0;
      start_edge_q   <= 2'b11;
      stop_edge_q    <= 2'b11;
      timeout_q      <= '0;
      count_q        <= '0;
      measured_q     <= '0;
      timed_out_q    <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_sync_q   <= start_sync_d;
      stop_sync_q    <= stop_sync_d;
      start_hist_q   <= start_hist_d;
      stop_hist_q    <= stop_hist_d;
      start_edge_q   <= start_edge_d;
      stop_edge_q    <= stop_edge_d;
      timeout_q      <= timeout_d;
      count_q        <= count_d;
      measured_q     <= measured_d;
      timed_out_q    <= timed_out_d;
      overflow_q     <= overflow_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy            = busy_q;
  assign result_valid    = result_valid_q;
  assign measured_cycles = measured_q;
  assign timed_out       = timed_out_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_trigger_latency_meter.sv
// Directed bench for trigger_latency_meter: a 32-bit and an 8-bit instance
// share stimulus; a behavioural delay path drives the loopback scenario.
module tb_trigger_latency_meter;

  localparam int DELAY_CYC = 1000;
  localparam int PIPE_LAT  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0;
  logic        stop_in = 1'b0;
  logic [1:0]  start_edge = 2'b00;
  logic [1:0]  stop_edge = 2'b00;
  logic [31:0] timeout_cycles = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;

  logic        busy, rv, tmo, ovf;
  logic [31:0] meas;
  logic        busy8, rv8, tmo8, ovf8;
  logic [7:0]  meas8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trigger_latency_meter #(.SYNC_STAGES(3), .CNT_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .stop_in(stop_in),
    .start_edge(start_edge), .stop_edge(stop_edge), .timeout_cycles(timeout_cycles),
    .arm(arm), .abort(abort), .busy(busy), .result_valid(rv),
    .measured_cycles(meas), .timed_out(tmo), .overflow(ovf)
  );

  trigger_latency_meter #(.SYNC_STAGES(3), .CNT_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .stop_in(stop_in),
    .start_edge(start_edge), .stop_edge(stop_edge), .timeout_cycles(timeout_cycles[7:0]),
    .arm(arm), .abort(abort), .busy(busy8), .result_valid(rv8),
    .measured_cycles(meas8), .timed_out(tmo8), .overflow(ovf8)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_abort;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic prep;
    pulse_abort();
    start_in = 1'b0;
    stop_in  = 1'b0;
    tick(8);
  endtask

  task automatic wait_done(input string name, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (rv === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: result_valid not seen within %0d cycles", name, maxc);
    end
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if ({busy, rv, tmo, ovf} !== 4'b0000 || meas !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b rv=%b tmo=%b ovf=%b meas=%0d expected all 0",
               busy, rv, tmo, ovf, meas);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic;
    start_edge = 2'b00; stop_edge = 2'b00; timeout_cycles = 0;
    prep();
    pulse_arm();
    checks++;
    if (busy !== 1'b1 || rv !== 1'b0) begin
      errors++;
      $display("FAIL arm_busy: busy=%b rv=%b expected 1 0", busy, rv);
    end
    tick(3);
    start_in = 1'b1;
    tick(100);
    stop_in = 1'b1;
    wait_done("basic_done", 20);
    checks++;
    if (meas !== 32'd100 || tmo !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic: meas=%0d tmo=%b ovf=%b busy=%b expected 100 0 0 0", meas, tmo, ovf, busy);
    end
    pulse_abort();
    checks++;
    if (rv !== 1'b0 || busy !== 1'b0 || meas !== 32'd100) begin
      errors++;
      $display("FAIL abort_hold: rv=%b busy=%b meas=%0d expected 0 0 100", rv, busy, meas);
    end
  endtask

  task automatic test_coincident;
    start_edge = 2'b00; stop_edge = 2'b00; timeout_cycles = 0;
    prep();
    pulse_arm();
    tick(3);
    start_in = 1'b1;
    stop_in  = 1'b1;
    wait_done("coinc_done", 20);
    checks++;
    if (meas !== 32'd0 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL coincident: meas=%0d tmo=%b expected 0 0", meas, tmo);
    end
  endtask

  task automatic test_both_edge;
    start_edge = 2'b10; stop_edge = 2'b00; timeout_cycles = 0;
    prep();
    start_in = 1'b1;
    tick(8);
    pulse_arm();
    tick(3);
    start_in = 1'b0;
    tick(7);
    stop_in = 1'b1;
    wait_done("both_done", 20);
    checks++;
    if (meas !== 32'd7) begin
      errors++;
      $display("FAIL both_edge: meas=%0d expected 7", meas);
    end
  endtask

  task automatic test_timeout;
    start_edge = 2'b00; stop_edge = 2'b00; timeout_cycles = 50;
    prep();
    pulse_arm();
    timeout_cycles = 0;
    tick(3);
    start_in = 1'b1;
    wait_done("timeout_done", 80);
    checks++;
    if (meas !== 32'd50 || tmo !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL timeout: meas=%0d tmo=%b ovf=%b expected 50 1 0", meas, tmo, ovf);
    end
    timeout_cycles = 50;
    prep();
    pulse_arm();
    tick(3);
    start_in = 1'b1;
    tick(50);
    stop_in = 1'b1;
    wait_done("stop_at_timeout_done", 80);
    checks++;
    if (meas !== 32'd50 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL stop_at_timeout: meas=%0d tmo=%b expected 50 0", meas, tmo);
    end
    timeout_cycles = 0;
  endtask

  task automatic test_overflow;
    start_edge = 2'b00; stop_edge = 2'b00; timeout_cycles = 0;
    prep();
    pulse_arm();
    tick(3);
    start_in = 1'b1;
    tick(300);
    stop_in = 1'b1;
    wait_done("overflow_done", 20);
    checks++;
    if (rv8 !== 1'b1 || meas8 !== 8'd255 || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL overflow8: rv=%b meas=%0d ovf=%b expected 1 255 1", rv8, meas8, ovf8);
    end
    checks++;
    if (meas !== 32'd300 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL wide300: meas=%0d ovf=%b expected 300 0", meas, ovf);
    end
  endtask

  task automatic test_back_to_back;
    start_edge = 2'b00; stop_edge = 2'b00; timeout_cycles = 0;
    prep();
    pulse_arm();
    tick(3);
    start_in = 1'b1;
    tick(5);
    stop_in = 1'b1;
    wait_done("b2b_done", 20);
    pulse_arm();
    checks++;
    if (busy !== 1'b1 || rv !== 1'b0 || meas !== 32'd0) begin
      errors++;
      $display("FAIL back_to_back: busy=%b rv=%b meas=%0d expected 1 0 0", busy, rv, meas);
    end
  endtask

  task automatic test_control;
    start_edge = 2'b00; stop_edge = 2'b00; timeout_cycles = 0;
    prep();
    pulse_arm();
    tick(2);
    start_in = 1'b1;
    tick(20);
    pulse_arm();
    tick(19);
    stop_in = 1'b1;
    wait_done("arm_ignored_done", 20);
    checks++;
    if (meas !== 32'd40) begin
      errors++;
      $display("FAIL arm_ignored: meas=%0d expected 40", meas);
    end

    prep();
    pulse_arm();
    tick(2);
    start_in = 1'b1;
    tick(10);
    pulse_abort();
    checks++;
    if (busy !== 1'b0 || rv !== 1'b0) begin
      errors++;
      $display("FAIL abort_mid: busy=%b rv=%b expected 0 0", busy, rv);
    end
    stop_in = 1'b1;
    tick(10);
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result: rv=%b expected 0", rv);
    end

    prep();
    arm = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    abort = 1'b0;
    tick(2);
    checks++;
    if (busy !== 1'b0 || rv !== 1'b0) begin
      errors++;
      $display("FAIL arm_abort: busy=%b rv=%b expected 0 0", busy, rv);
    end

    start_edge = 2'b11;
    prep();
    pulse_arm();
    tick(2);
    start_in = 1'b1;
    tick(10);
    stop_in = 1'b1;
    tick(10);
    checks++;
    if (busy !== 1'b1 || rv !== 1'b0) begin
      errors++;
      $display("FAIL start_disabled: busy=%b rv=%b expected 1 0", busy, rv);
    end
    start_edge = 2'b00;
  endtask

  task automatic test_reset_mid;
    start_edge = 2'b00; stop_edge = 2'b00; timeout_cycles = 0;
    prep();
    pulse_arm();
    tick(2);
    start_in = 1'b1;
    tick(10);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, rv, tmo, ovf} !== 4'b0000 || meas !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b rv=%b tmo=%b ovf=%b meas=%0d expected all 0",
               busy, rv, tmo, ovf, meas);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stop_in = 1'b1;
    tick(10);
    checks++;
    if (rv !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_result: rv=%b busy=%b expected 0 0", rv, busy);
    end
  endtask

  task automatic test_loopback;
    int offs[8] = '{1, 2, 3, 4, 6, 7, 8, 9};
    int expv = DELAY_CYC + PIPE_LAT;
    int m;
    start_edge = 2'b00; stop_edge = 2'b00; timeout_cycles = 0;
    for (int r = 0; r < 20; r++) begin
      prep();
      pulse_arm();
      tick($urandom_range(1, 5));
      #(offs[$urandom_range(0, 7)]);
      start_in = 1'b1;
      #((DELAY_CYC + PIPE_LAT) * 10);
      stop_in = 1'b1;
      @(negedge clk);
      wait_done("loopback_done", 20);
      m = int'(meas);
      checks++;
      if (m < expv - 1 || m > expv + 1) begin
        errors++;
        $display("FAIL loopback run %0d: meas=%0d expected %0d +/-1", r, m, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_coincident();
    test_both_edge();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_control();
    test_reset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
